// File: rtl/wb_mtimer_pkg.sv
// Machine timer shared definitions.
// Register offsets, bus FSM state type and byte-lane merge helper.
package wb_mtimer_pkg;

    localparam logic [2:0] ADR_MTIME_LO = 3'd0;
    localparam logic [2:0] ADR_MTIME_HI = 3'd1;
    localparam logic [2:0] ADR_CMP_LO   = 3'd2;
    localparam logic [2:0] ADR_CMP_HI   = 3'd3;
    localparam logic [2:0] ADR_MSIP     = 3'd4;
    localparam logic [2:0] ADR_DIV      = 3'd5;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = sel[i] ? data[i*8 +: 8]
                                 : old[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Machine timer prescaler.
// Emits one tick every div+1 clocks; clear restarts the count.
module mtimer_prescaler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] div,
    input  logic        clear,
    output logic        tick
);

    logic [31:0] count;

    assign tick = (count == div);

    // Count up to div, then wrap to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/wishbone_mtimer.sv
// Wishbone classic RISC-V machine timer.
// MTIME/MTIMECMP/MSIP/DIV registers with single-cycle termination.
module wishbone_mtimer
    import wb_mtimer_pkg::*;
#(
    parameter logic [31:0] DEFAULT_DIV    = 32'd0,
    parameter logic [63:0] RESET_MTIMECMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] wb_adr,
    input  logic [31:0] wb_dat_w,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic        wb_cti,
    input  logic        wb_bte,
    output logic [31:0] wb_dat_r,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        timer_irq,
    output logic        soft_irq
);

    state_t      state;
    state_t      state_next;
    logic        req;
    logic        mapped;
    logic        wr;
    logic        rd;
    logic [2:0]  adr;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow;
    logic [31:0] div;
    logic [31:0] rdata;
    logic        msip;
    logic        tick;
    logic        div_wr;
    logic        unused;

    assign unused = ^{wb_cti, wb_bte, wb_adr[29:3]};

    assign adr    = wb_adr[2:0];
    assign mapped = (adr <= ADR_DIV);
    assign wr     = req && mapped && wb_we
                 && (|wb_sel);
    assign rd     = req && mapped && !wb_we;
    assign div_wr = wr && (adr == ADR_DIV);
    assign soft_irq = msip;

    // Accept a request only from IDLE; RESP lasts one cycle
    always_comb begin
        state_next = state;
        req        = 1'b0;
        unique case (state)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    req        = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: state_next = IDLE;
        endcase
    end

    // Bus FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read mux over pre-update register values
    always_comb begin
        rdata = '0;
        unique case (adr)
            ADR_MTIME_LO: rdata = mtime[31:0];
            ADR_MTIME_HI: rdata = shadow;
            ADR_CMP_LO:   rdata = mtimecmp[31:0];
            ADR_CMP_HI:   rdata = mtimecmp[63:32];
            ADR_MSIP:     rdata = {31'b0, msip};
            ADR_DIV:      rdata = div;
            default:      rdata = '0;
        endcase
    end

    // Termination and read data, raised at the request edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack   <= 1'b0;
            wb_err   <= 1'b0;
            wb_dat_r <= '0;
        end else begin
            wb_ack   <= req && mapped;
            wb_err   <= req && !mapped;
            wb_dat_r <= rd ? rdata : '0;
        end
    end

    // Low-word read snapshots the high word for tear-free reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (rd && (adr == ADR_MTIME_LO)) begin
            shadow <= mtime[63:32];
        end
    end

    // MTIME: bus write wins over the tick increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else if (wr && (adr == ADR_MTIME_LO)) begin
            mtime[31:0] <= byte_merge(mtime[31:0],
                                      wb_dat_w, wb_sel);
        end else if (wr && (adr == ADR_MTIME_HI)) begin
            mtime[63:32] <= byte_merge(mtime[63:32],
                                       wb_dat_w, wb_sel);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Control registers: MTIMECMP, MSIP, DIV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtimecmp <= RESET_MTIMECMP;
            msip     <= 1'b0;
            div      <= DEFAULT_DIV;
        end else if (wr) begin
            unique case (adr)
                ADR_CMP_LO:
                    mtimecmp[31:0] <= byte_merge(
                        mtimecmp[31:0], wb_dat_w, wb_sel);
                ADR_CMP_HI:
                    mtimecmp[63:32] <= byte_merge(
                        mtimecmp[63:32], wb_dat_w, wb_sel);
                ADR_MSIP:
                    if (wb_sel[0]) msip <= wb_dat_w[0];
                ADR_DIV:
                    div <= byte_merge(div, wb_dat_w, wb_sel);
                default: ;
            endcase
        end
    end

    // Registered timer compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= (mtime >= mtimecmp);
        end
    end

    mtimer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (div),
        .clear (div_wr),
        .tick  (tick)
    );

endmodule

// File: tb/tb_wishbone_mtimer.sv
// Bench for wishbone_mtimer.
// Random bus traffic against a behavioural model plus directed cases.
module tb_wishbone_mtimer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [29:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        cyc, stb, we, cti, bte;
    logic [31:0] wb_dat_r;
    logic        wb_ack, wb_err, timer_irq, soft_irq;

    int total = 0;
    int bad = 0;

    // behavioural model state
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_pcnt, m_div, m_shadow;
    logic        m_msip, m_busy;
    logic        exp_ack, exp_err, exp_tirq;
    logic [31:0] exp_dat;
    int          n_edges;

    logic [31:0] r, d;
    logic        ak, er;
    logic [2:0]  a;
    logic [3:0]  s;
    logic        w;
    int          guard;

    always #5 clk = ~clk;

    wishbone_mtimer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_adr    (adr),
        .wb_dat_w  (dat_w),
        .wb_sel    (sel),
        .wb_cyc    (cyc),
        .wb_stb    (stb),
        .wb_we     (we),
        .wb_cti    (cti),
        .wb_bte    (bte),
        .wb_dat_r  (wb_dat_r),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq)
    );

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] bs);
        logic [31:0] res;
        res = o;
        for (int i = 0; i < 4; i++)
            if (bs[i]) res[i*8 +: 8] = n[i*8 +: 8];
        return res;
    endfunction

    task automatic model_reset();
        m_mtime  = 64'd0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_pcnt   = 32'd0;
        m_div    = 32'd0;
        m_shadow = 32'd0;
        m_msip   = 1'b0;
        m_busy   = 1'b0;
        exp_ack  = 1'b0;
        exp_err  = 1'b0;
        exp_tirq = 1'b0;
        exp_dat  = 32'd0;
    endtask

    // One clock edge of the timer as the register map describes it
    task automatic model_edge();
        logic        req, map, tick;
        logic [63:0] mt;
        logic [31:0] pc, rdv;
        logic [2:0]  ad;
        if (!rst_n) return;
        n_edges++;
        ad   = adr[2:0];
        req  = !m_busy && cyc && stb;
        map  = (ad <= 3'd5);
        tick = (m_pcnt == m_div);
        rdv  = 32'd0;
        if (req && map && !we) begin
            case (ad)
                3'd0: rdv = m_mtime[31:0];
                3'd1: rdv = m_shadow;
                3'd2: rdv = m_cmp[31:0];
                3'd3: rdv = m_cmp[63:32];
                3'd4: rdv = {31'b0, m_msip};
                default: rdv = m_div;
            endcase
            if (ad == 3'd0) m_shadow = m_mtime[63:32];
        end
        exp_tirq = (m_mtime >= m_cmp);
        mt = tick ? m_mtime + 64'd1 : m_mtime;
        pc = tick ? 32'd0 : m_pcnt + 32'd1;
        if (req && map && we && sel != 4'd0) begin
            case (ad)
                3'd0: mt = {m_mtime[63:32],
                            merge(m_mtime[31:0], dat_w, sel)};
                3'd1: mt = {merge(m_mtime[63:32], dat_w, sel),
                            m_mtime[31:0]};
                3'd2: m_cmp[31:0] = merge(m_cmp[31:0], dat_w, sel);
                3'd3: m_cmp[63:32] = merge(m_cmp[63:32], dat_w, sel);
                3'd4: if (sel[0]) m_msip = dat_w[0];
                default: begin
                    m_div = merge(m_div, dat_w, sel);
                    pc = 32'd0;
                end
            endcase
        end
        m_mtime = mt;
        m_pcnt  = pc;
        m_busy  = req;
        exp_ack = req && map;
        exp_err = req && !map;
        exp_dat = rdv;
    endtask

    // Per-cycle comparison of every DUT output against the model
    task automatic compare_cycle();
        check("ack", 64'(wb_ack), 64'(exp_ack));
        check("err", 64'(wb_err), 64'(exp_err));
        check("timer_irq", 64'(timer_irq), 64'(exp_tirq));
        check("soft_irq", 64'(soft_irq), 64'(m_msip));
        if (exp_ack || exp_err)
            check("dat_r", 64'(wb_dat_r), 64'(exp_dat));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic do_reset();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        n_edges = 0;
    endtask

    // hold keeps stb up through RESP to show it is ignored
    task automatic access(input logic wr_en,
                          input logic [2:0] ad,
                          input logic [31:0] dv,
                          input logic [3:0] bs,
                          input logic hold,
                          output logic [31:0] rv,
                          output logic ack_o,
                          output logic err_o);
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = wr_en;
        adr   = {27'b0, ad};
        dat_w = dv;
        sel   = bs;
        step();
        rv    = wb_dat_r;
        ack_o = wb_ack;
        err_o = wb_err;
        if (!hold) begin
            cyc = 1'b0;
            stb = 1'b0;
        end
        step();
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        adr = '0; dat_w = '0; sel = '0;
        cyc = 0; stb = 0; we = 0; cti = 0; bte = 0;
        model_reset();
        n_edges = 0;
        #1;
        check("rst ack", 64'(wb_ack), 64'd0);
        check("rst err", 64'(wb_err), 64'd0);
        check("rst dat", 64'(wb_dat_r), 64'd0);
        check("rst tirq", 64'(timer_irq), 64'd0);
        check("rst sirq", 64'(soft_irq), 64'd0);

        // 10 idle edges; the read samples MTIME before its own edge
        do_reset();
        repeat (10) step();
        access(1'b0, 3'd0, 32'd0, 4'hF, 1'b0, r, ak, er);
        check("idle10 mtime_lo", 64'(r), 64'd10);
        check("idle10 ack", 64'(ak), 64'd1);

        // carry from low to high word seen through the shadow
        access(1'b1, 3'd5, 32'd0, 4'hF, 1'b0, r, ak, er);
        access(1'b1, 3'd1, 32'd0, 4'hF, 1'b0, r, ak, er);
        access(1'b1, 3'd0, 32'hFFFF_FFFF, 4'hF, 1'b0, r, ak, er);
        access(1'b0, 3'd0, 32'd0, 4'hF, 1'b0, r, ak, er);
        check("carry lo", 64'(r), 64'd0);
        access(1'b0, 3'd1, 32'd0, 4'hF, 1'b0, r, ak, er);
        check("carry hi shadow", 64'(r), 64'd1);

        // compare at 20: MTIME==20 after edge 20, irq after edge 21
        do_reset();
        access(1'b1, 3'd3, 32'd0, 4'hF, 1'b0, r, ak, er);
        access(1'b1, 3'd2, 32'd20, 4'hF, 1'b0, r, ak, er);
        guard = 0;
        while (!timer_irq && guard < 100) begin
            step();
            guard++;
        end
        check("tirq rise edge", 64'(n_edges), 64'd21);
        cyc = 1'b1; stb = 1'b1; we = 1'b1;
        adr = 30'd2; dat_w = 32'hFFFF_FFFF; sel = 4'hF;
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("tirq at cmp write", 64'(timer_irq), 64'd1);
        step();
        check("tirq dropped", 64'(timer_irq), 64'd0);

        // unmapped offset
        access(1'b0, 3'd6, 32'd0, 4'hF, 1'b0, r, ak, er);
        check("unmapped err", 64'(er), 64'd1);
        check("unmapped ack", 64'(ak), 64'd0);
        check("unmapped dat", 64'(r), 64'd0);

        // MSIP byte enables
        access(1'b1, 3'd4, 32'd1, 4'b0001, 1'b0, r, ak, er);
        check("msip set", 64'(soft_irq), 64'd1);
        access(1'b1, 3'd4, 32'd0, 4'b0000, 1'b0, r, ak, er);
        check("msip sel0 ack", 64'(ak), 64'd1);
        check("msip sel0 keep", 64'(soft_irq), 64'd1);

        // reset in the middle of a response
        access(1'b1, 3'd5, 32'd7, 4'hF, 1'b0, r, ak, er);
        access(1'b1, 3'd3, 32'd0, 4'hF, 1'b0, r, ak, er);
        access(1'b1, 3'd2, 32'd0, 4'hF, 1'b0, r, ak, er);
        step();
        check("pre-abort tirq", 64'(timer_irq), 64'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 30'd5;
        @(posedge clk);
        model_edge();
        #2;
        check("pre-abort ack", 64'(wb_ack), 64'd1);
        check("pre-abort dat", 64'(wb_dat_r), 64'd7);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort ack", 64'(wb_ack), 64'd0);
        check("abort err", 64'(wb_err), 64'd0);
        check("abort dat", 64'(wb_dat_r), 64'd0);
        check("abort tirq", 64'(timer_irq), 64'd0);
        check("abort sirq", 64'(soft_irq), 64'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        n_edges = 0;
        repeat (3) step();
        access(1'b0, 3'd5, 32'd0, 4'hF, 1'b0, r, ak, er);
        check("div after reset", 64'(r), 64'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            a = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            if (a == 3'd5) d = 32'($urandom_range(0, 3));
            if (a == 3'd2)
                d = m_mtime[31:0] + 32'($urandom_range(0, 40));
            if (a == 3'd3) d = m_mtime[63:32];
            cti = 1'($urandom);
            bte = 1'($urandom);
            access(w, a, d, s, 1'($urandom_range(0, 1)),
                   r, ak, er);
            repeat ($urandom_range(0, 3)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
